alu_multicycle: RTL and testbench

Parametrised, registered ALU that extends the combinational add/sub/and/or datapath with shifts and iterative signed multiply/divide behind a valid/ready handshake. It sits in the execute stage of the processor: the pipeline controller issues one operation at a time, and the ALU stalls issue (in_ready low) while a multicycle operation is in flight. Results and flags are held stable until the consumer accepts them.

---
 rtl/alu_multicycle.sv | 214 +++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Registered ALU: single-cycle add/sub/logic/shift ops plus iterative signed mul/div
// behind a valid/ready handshake; results and flags are held until the next result.
module alu_multicycle #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               ctrl_reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  input  logic [4:0]         ctrl_ALUopcode,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_result,
  output logic               isNotEqual,
  output logic               isLessThan,
  output logic               overflow,
  output logic               exception
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned DW    = 2 * WIDTH;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;
  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ne_q, ne_d, lt_q, lt_d, ovf_q, ovf_d, exc_q, exc_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               is_div_q, is_div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // acc: mul partial product / div remainder; mcand: multiplicand / divisor;
  // shreg: multiplier bits consumed LSB-first / dividend shifted into quotient.
  logic [DW-1:0]      acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;

  logic [WIDTH-1:0]   cmp_a, cmp_b, sum, diff, a_mag, b_mag;
  logic               add_ovf, sub_ovf, lt_c, ne_c, neg;
  logic [DW-1:0]      acc_mul, prod;
  logic [WIDTH:0]     rem_sh, rem_nx;
  logic               rem_ge;
  logic [WIDTH-1:0]   quo_nx, quo_s;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ne_q        <= 1'b0;
      lt_q        <= 1'b0;
      ovf_q       <= 1'b0;
      exc_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      is_div_q    <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      shreg_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ne_q        <= ne_d;
      lt_q        <= lt_d;
      ovf_q       <= ovf_d;
      exc_q       <= exc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      is_div_q    <= is_div_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      shreg_q     <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ne_d     = ne_q;
    lt_d     = lt_q;
    ovf_d    = ovf_q;
    exc_d    = exc_q;
    a_d      = a_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    shreg_d  = shreg_q;

    // Flags come from the live inputs on the accept edge, from the captured copy otherwise.
    cmp_a   = (state_q == IDLE) ? data_operandA : a_q;
    cmp_b   = (state_q == IDLE) ? data_operandB : b_q;
    sum     = cmp_a + cmp_b;
    diff    = cmp_a - cmp_b;
    add_ovf = (cmp_a[WIDTH-1] == cmp_b[WIDTH-1]) && (sum[WIDTH-1] != cmp_a[WIDTH-1]);
    sub_ovf = (cmp_a[WIDTH-1] != cmp_b[WIDTH-1]) && (diff[WIDTH-1] != cmp_a[WIDTH-1]);
    lt_c    = diff[WIDTH-1] ^ sub_ovf;
    ne_c    = (cmp_a != cmp_b);
    neg     = cmp_a[WIDTH-1] ^ cmp_b[WIDTH-1];
    a_mag   = cmp_a[WIDTH-1] ? -cmp_a : cmp_a;
    b_mag   = cmp_b[WIDTH-1] ? -cmp_b : cmp_b;

    acc_mul = acc_q + (shreg_q[0] ? mcand_q : '0);
    prod    = neg ? -acc_mul : acc_mul;
    rem_sh  = {acc_q[WIDTH-1:0], shreg_q[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, mcand_q[WIDTH-1:0]});
    rem_nx  = rem_ge ? (rem_sh - {1'b0, mcand_q[WIDTH-1:0]}) : rem_sh;
    quo_nx  = {shreg_q[WIDTH-2:0], rem_ge};
    quo_s   = neg ? -quo_nx : quo_nx;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = data_operandA;
          b_d     = data_operandB;
          ne_d    = ne_c;
          lt_d    = lt_c;
          ovf_d   = 1'b0;
          exc_d   = 1'b0;
          state_d = DONE;
          case (ctrl_ALUopcode)
            OP_ADD: begin result_d = sum;  ovf_d = add_ovf; end
            OP_SUB: begin result_d = diff; ovf_d = sub_ovf; end
            OP_AND: result_d = cmp_a & cmp_b;
            OP_OR:  result_d = cmp_a | cmp_b;
            OP_SLL: result_d = cmp_a << ctrl_shiftamt;
            OP_SRA: result_d = WIDTH'($signed(cmp_a) >>> ctrl_shiftamt);
            OP_MUL, OP_DIV: begin
              // Flags and result stay untouched until the iteration finishes.
              ne_d     = ne_q;
              lt_d     = lt_q;
              ovf_d    = ovf_q;
              exc_d    = exc_q;
              state_d  = BUSY;
              is_div_d = (ctrl_ALUopcode == OP_DIV);
              cnt_d    = CNT_W'(WIDTH);
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, (ctrl_ALUopcode == OP_DIV) ? b_mag : a_mag};
              shreg_d  = (ctrl_ALUopcode == OP_DIV) ? a_mag : b_mag;
            end
            default: begin result_d = '0; exc_d = 1'b1; end
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (is_div_q) begin
          acc_d   = {{(WIDTH-1){1'b0}}, rem_nx};
          shreg_d = quo_nx;
        end else begin
          acc_d   = acc_mul;
          mcand_d = mcand_q << 1;
          shreg_d = shreg_q >> 1;
        end
        // Last step: apply sign to the freshly computed magnitude and publish.
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          ne_d    = ne_c;
          lt_d    = lt_c;
          if (!is_div_q) begin
            result_d = prod[WIDTH-1:0];
            ovf_d    = (prod[DW-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
            exc_d    = 1'b0;
          end else if (b_q == '0) begin
            result_d = '0;
            ovf_d    = 1'b0;
            exc_d    = 1'b1;
          end else begin
            result_d = quo_s;
            ovf_d    = (a_q == MIN_VAL) && (b_q == '1);
            exc_d    = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign data_result = result_q;
  assign isNotEqual  = ne_q;
  assign isLessThan  = lt_q;
  assign overflow    = ovf_q;
  assign exception   = exc_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH=32): expected results queued at issue,
// popped and compared when out_valid rises.
module tb_alu_multicycle;

  logic        clock;
  logic        ctrl_reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [4:0]  ctrl_ALUopcode;
  logic [4:0]  ctrl_shiftamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_result;
  logic        isNotEqual;
  logic        isLessThan;
  logic        overflow;
  logic        exception;

  typedef struct packed {
    logic [31:0] r;
    logic        ne;
    logic        lt;
    logic        ovf;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock          (clock),
    .ctrl_reset_n   (ctrl_reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_ALUopcode (ctrl_ALUopcode),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .data_result    (data_result),
    .isNotEqual     (isNotEqual),
    .isLessThan     (isLessThan),
    .overflow       (overflow),
    .exception      (exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed still running, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] r, input logic ne, input logic lt,
                      input logic ovf, input logic exc);
    exp_t e;
    e.r = r; e.ne = ne; e.lt = lt; e.ovf = ovf; e.exc = exc;
    sb.push_back(e);
  endtask

  // Independent reference built on wide native arithmetic.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh);
    exp_t        e;
    logic [63:0] p;
    e     = '0;
    e.ne  = (a != b);
    e.lt  = ($signed(a) < $signed(b));
    case (op)
      5'd0: begin e.r = a + b; e.ovf = (a[31] == b[31]) && (e.r[31] != a[31]); end
      5'd1: begin e.r = a - b; e.ovf = (a[31] != b[31]) && (e.r[31] != a[31]); end
      5'd2: e.r = a & b;
      5'd3: e.r = a | b;
      5'd4: e.r = a << sh;
      5'd5: e.r = 32'($signed(a) >>> sh);
      5'd6: begin
        p     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        e.r   = p[31:0];
        e.ovf = (p[63:32] != {32{p[31]}});
      end
      5'd7: begin
        if (b == 32'd0) e.exc = 1'b1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.r = 32'h8000_0000; e.ovf = 1'b1;
        end else e.r = 32'($signed(a) / $signed(b));
      end
      default: e.exc = 1'b1;
    endcase
    return e;
  endfunction

  // Waits (bounded) for in_ready, presents one request, accepts on the next rising edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    int guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clock); #1; guard++; end
    if (!in_ready) chk("issue_ready_timeout", 64'(in_ready), 64'd1);
    in_valid       = 1'b1;
    data_operandA  = a;
    data_operandB  = b;
    ctrl_ALUopcode = op;
    ctrl_shiftamt  = sh;
    @(posedge clock); #1;
    in_valid       = 1'b0;
    data_operandA  = $urandom;
    data_operandB  = $urandom;
    ctrl_ALUopcode = 5'($urandom);
    ctrl_shiftamt  = 5'($urandom);
  endtask

  // Counts latency from the accept edge, then compares against the queued expectation.
  task automatic collect(input string tag, input int exp_lat);
    int   lat = 1;
    logic rdy_seen = 1'b0;
    exp_t e;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_ready_low"}, 64'(rdy_seen | in_ready), 64'd0);
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_result"},   64'(data_result), 64'(e.r));
      chk({tag, "_notequal"}, 64'(isNotEqual),  64'(e.ne));
      chk({tag, "_lessthan"}, 64'(isLessThan),  64'(e.lt));
      chk({tag, "_overflow"}, 64'(overflow),    64'(e.ovf));
      chk({tag, "_exception"},64'(exception),   64'(e.exc));
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk({tag, "_idle"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] sh, input int lat);
    issue(op, a, b, sh);
    collect(tag, lat);
    release_result(tag);
  endtask

  initial begin
    logic [31:0] hold_r;
    logic [3:0]  hold_f;
    logic        stable;
    logic [31:0] ra, rb;
    logic [4:0]  rop;
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    data_operandA  = '0;
    data_operandB  = '0;
    ctrl_ALUopcode = '0;
    ctrl_shiftamt  = '0;
    ctrl_reset_n   = 1'b0;
    #23;
    chk("reset_in_ready",  64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", {28'd0, data_result, isNotEqual, isLessThan, overflow, exception}, 64'd0);
    @(negedge clock) ctrl_reset_n = 1'b1;

    push(32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run("add_ovf", 5'b00000, 32'h7FFF_FFFF, 32'd1, 5'd0, 1);
    push(32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0);
    run("sub_neg", 5'b00001, 32'd5, 32'd9, 5'd0, 1);
    push(32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    run("add_min_min", 5'b00000, 32'h8000_0000, 32'h8000_0000, 5'd0, 1);
    push(32'h00F0_1234, 1'b1, 1'b1, 1'b0, 1'b0);
    run("and", 5'b00010, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 1);
    push(32'h0000_00FF, 1'b1, 1'b0, 1'b0, 1'b0);
    run("or", 5'b00011, 32'h0000_00F0, 32'h0000_000F, 5'd0, 1);
    push(32'hF800_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    run("sra", 5'b00101, 32'h8000_0000, 32'd0, 5'd4, 1);
    push(32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    run("sll", 5'b00100, 32'd1, 32'd0, 5'd31, 1);
    push(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    run("bad_opcode", 5'b01010, 32'd3, 32'd3, 5'd0, 1);
    push(32'hFFFF_FFD6, 1'b1, 1'b1, 1'b0, 1'b0);
    run("mul_neg", 5'b00110, 32'hFFFF_FFF9, 32'd6, 5'd0, 33);
    push(32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0);
    run("mul_ovf", 5'b00110, 32'h7FFF_FFFF, 32'd2, 5'd0, 33);
    push(32'hFFFF_FFFD, 1'b1, 1'b1, 1'b0, 1'b0);
    run("div_neg", 5'b00111, 32'hFFFF_FFF9, 32'd2, 5'd0, 33);
    push(32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    run("div_zero", 5'b00111, 32'd10, 32'd0, 5'd0, 33);
    push(32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
    run("div_min_m1", 5'b00111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 33);

    for (int i = 0; i < 8; i++) begin
      ra  = $urandom;
      rb  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)) ^ {32{ra[0]}};
      rop = 5'(i % 8);
      sb.push_back(model(rop, ra, rb, 5'(i * 3)));
      run("model_op", rop, ra, rb, 5'(i * 3), (rop == 5'd6 || rop == 5'd7) ? 33 : 1);
    end

    // Reset in the middle of a multiply discards it and clears outputs at once.
    issue(5'b00110, 32'd1234, 32'd5678, 5'd0);
    repeat (9) begin @(posedge clock); #1; end
    ctrl_reset_n = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_in_ready",  64'(in_ready),  64'd1);
    chk("midreset_outputs", {28'd0, data_result, isNotEqual, isLessThan, overflow, exception}, 64'd0);
    @(negedge clock) ctrl_reset_n = 1'b1;
    push(32'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    run("post_reset_add", 5'b00000, 32'd3, 32'd4, 5'd0, 1);

    // Backpressure: hold the result, poke in_valid, confirm nothing moves.
    push(32'd99, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(5'b00001, 32'd100, 32'd1, 5'd0);
    collect("bp", 1);
    hold_r = data_result;
    hold_f = {isNotEqual, isLessThan, overflow, exception};
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid       = (c % 3 == 0);
      data_operandA  = $urandom;
      data_operandB  = $urandom;
      ctrl_ALUopcode = 5'b00000;
      @(posedge clock); #1;
      if (data_result !== hold_r || {isNotEqual, isLessThan, overflow, exception} !== hold_f ||
          out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    chk("bp_hold_stable", 64'(stable), 64'd1);
    chk("bp_result_hold", 64'(data_result), 64'd99);
    release_result("bp");
    chk("idle_result_hold", 64'(data_result), 64'd99);
    push(32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    run("bp_next", 5'b00000, 32'd1, 32'd1, 5'd0, 1);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
